pointer_unit: RTL and testbench

- Holds the 16-bit instruction pointer IP and the data pointer DP = {PH, PL}.
- Sits directly downstream of the control unit and consumes its ip_inc, swap_p, addr_dp, we_pl, we_ph, oe_pl_alu and oe_ph_alu outputs.
- Drives the external address bus and supplies PL/PH to the ALU B input.
- Loads DP bytes from the DI bus, increments IP, and performs jumps by exchanging IP and DP.

---
 rtl/pointer_unit_pkg.sv | 18 +
 rtl/pointer_unit_ptr_reg16.sv | 35 +++
 rtl/pointer_unit.sv | 69 ++++++
 tb/tb_pointer_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pointer_unit_pkg.sv
// Shared widths, active-low enable encodings and reset vectors for the pointer unit.
package pointer_unit_pkg;

  localparam int PTR_W  = 16;
  localparam int BYTE_W = 8;

  localparam logic EN_N  = 1'b0;
  localparam logic DIS_N = 1'b1;

  localparam logic [PTR_W-1:0] RESET_IP_VEC = 16'h0000;
  localparam logic [PTR_W-1:0] RESET_DP_VEC = 16'h0000;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input logic             inc);
    return base + {{(PTR_W-1){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/pointer_unit_ptr_reg16.sv
// 16-bit negedge pointer register: optional full-word load, per-byte writes override
// the load for their byte, async active-low reset.
module ptr_reg16
  import pointer_unit_pkg::*;
#(
  parameter logic [PTR_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PTR_W-1:0]  load_val,
  input  logic              we_lo_n,
  input  logic              we_hi_n,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [PTR_W-1:0]  q
);

  logic [PTR_W-1:0] q_q;
  logic [PTR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) q_d = load_val;
    if (we_lo_n == EN_N) q_d[BYTE_W-1:0]     = byte_in;
    if (we_hi_n == EN_N) q_d[PTR_W-1:BYTE_W] = byte_in;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) q_q <= RESET_VAL;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pointer_unit.sv
// Instruction pointer and data pointer pair: increment, jump-by-exchange, byte loads
// of DP from the DI bus, address mux and ALU B operand drive.
module pointer_unit
  import pointer_unit_pkg::*;
#(
  parameter logic [PTR_W-1:0] RESET_IP = RESET_IP_VEC,
  parameter logic [PTR_W-1:0] RESET_DP = RESET_DP_VEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] di,
  input  logic              ip_inc,
  input  logic              swap_p,
  input  logic              addr_dp,
  input  logic              we_pl,
  input  logic              we_ph,
  input  logic              oe_pl_alu,
  input  logic              oe_ph_alu,
  output logic [PTR_W-1:0]  addr,
  output logic [BYTE_W-1:0] alu_b,
  output logic              alu_b_drive,
  output logic              oe_conflict,
  output logic [PTR_W-1:0]  ip,
  output logic [PTR_W-1:0]  dp
);

  logic [PTR_W-1:0] ip_src;
  logic [PTR_W-1:0] dp_src;
  logic [PTR_W-1:0] ip_load_val;

  // Both sources use the pre-edge registers, so DP gets the old, unincremented IP.
  always_comb begin
    ip_src      = swap_p ? dp : ip;
    dp_src      = swap_p ? ip : dp;
    ip_load_val = ptr_add(ip_src, ip_inc);
  end

  ptr_reg16 #(.RESET_VAL(RESET_IP)) u_ip_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (swap_p | ip_inc),
    .load_val (ip_load_val),
    .we_lo_n  (DIS_N),
    .we_hi_n  (DIS_N),
    .byte_in  (di),
    .q        (ip)
  );

  ptr_reg16 #(.RESET_VAL(RESET_DP)) u_dp_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (swap_p),
    .load_val (dp_src),
    .we_lo_n  (we_pl),
    .we_hi_n  (we_ph),
    .byte_in  (di),
    .q        (dp)
  );

  always_comb begin
    addr        = addr_dp ? dp : ip;
    alu_b_drive = (oe_pl_alu == EN_N) | (oe_ph_alu == EN_N);
    oe_conflict = (oe_pl_alu == EN_N) & (oe_ph_alu == EN_N);
    alu_b       = '0;
    if (oe_pl_alu == EN_N)      alu_b = dp[BYTE_W-1:0];
    else if (oe_ph_alu == EN_N) alu_b = dp[PTR_W-1:BYTE_W];
  end

endmodule

// File: tb/tb_pointer_unit.sv
// Directed bench for pointer_unit: per-cycle IP/DP predictions queued at drive time and
// checked after the negedge, plus constant checks for the combinational outputs.
module tb_pointer_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  di;
  logic        ip_inc, swap_p, addr_dp, we_pl, we_ph, oe_pl_alu, oe_ph_alu;
  logic [15:0] addr, ip, dp;
  logic [7:0]  alu_b;
  logic        alu_b_drive, oe_conflict;

  int vec_cnt = 0;
  int mis_cnt = 0;

  typedef struct {
    logic [15:0] ip;
    logic [15:0] dp;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] m_ip, m_dp;

  pointer_unit dut (
    .clk(clk), .rst(rst), .di(di), .ip_inc(ip_inc), .swap_p(swap_p),
    .addr_dp(addr_dp), .we_pl(we_pl), .we_ph(we_ph),
    .oe_pl_alu(oe_pl_alu), .oe_ph_alu(oe_ph_alu),
    .addr(addr), .alu_b(alu_b), .alu_b_drive(alu_b_drive),
    .oe_conflict(oe_conflict), .ip(ip), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vec_cnt++;
    assert (obs === exp_v) else begin
      mis_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // One clock of stimulus: drive mid-high phase, predict, then compare after the negedge.
  task automatic step(input string tag, input logic inc, input logic swp,
                      input logic wpl, input logic wph, input logic [7:0] d);
    exp_t e;
    logic [15:0] src_i, src_d;
    @(posedge clk);
    ip_inc = inc; swap_p = swp; we_pl = wpl; we_ph = wph; di = d;
    src_i = swp ? m_dp : m_ip;
    src_d = swp ? m_ip : m_dp;
    e.ip  = src_i + {15'd0, inc};
    e.dp  = src_d;
    if (!wpl) e.dp[7:0]  = d;
    if (!wph) e.dp[15:8] = d;
    sb_q.push_back(e);
    m_ip = e.ip;
    m_dp = e.dp;
    @(negedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vec_cnt++; mis_cnt++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".ip"}, ip, e.ip);
      chk({tag, ".dp"}, dp, e.dp);
    end
    ip_inc = 1'b0; swap_p = 1'b0; we_pl = 1'b1; we_ph = 1'b1; di = 8'h00;
  endtask

  initial begin
    rst = 1'b0; di = 8'h00; ip_inc = 1'b0; swap_p = 1'b0; addr_dp = 1'b0;
    we_pl = 1'b1; we_ph = 1'b1; oe_pl_alu = 1'b1; oe_ph_alu = 1'b1;
    m_ip = 16'h0000; m_dp = 16'h0000;
    #1;
    chk("rst.ip", ip, 16'h0000);
    chk("rst.dp", dp, 16'h0000);
    chk("rst.alu_drv", {15'd0, alu_b_drive}, 16'h0000);
    @(posedge clk); #1 rst = 1'b1;

    // Increment
    step("inc1", 1, 0, 1, 1, 8'h00);
    step("inc2", 1, 0, 1, 1, 8'h00);
    step("inc3", 1, 0, 1, 1, 8'h00);
    chk("inc.ip", ip, 16'h0003);
    chk("addr.ip", addr, 16'h0003);
    addr_dp = 1'b1; #1;
    chk("addr.dp", addr, 16'h0000);
    addr_dp = 1'b0;

    // Byte loads of DP
    step("wpl34", 0, 0, 0, 1, 8'h34);
    step("wph12", 0, 0, 1, 0, 8'h12);
    chk("dp1234", dp, 16'h1234);
    oe_ph_alu = 1'b0; #1;
    chk("alub.ph", {8'h00, alu_b}, 16'h0012);
    chk("alub.drv", {15'd0, alu_b_drive}, 16'h0001);
    chk("alub.cfl0", {15'd0, oe_conflict}, 16'h0000);
    oe_ph_alu = 1'b1;

    // Swap with and without increment
    step("inc4", 1, 0, 1, 1, 8'h00);
    step("inc5", 1, 0, 1, 1, 8'h00);
    step("swpinc", 1, 1, 1, 1, 8'h00);
    chk("swpinc.ip", ip, 16'h1235);
    chk("swpinc.dp", dp, 16'h0005);
    step("swp", 0, 1, 1, 1, 8'h00);
    chk("swp.ip", ip, 16'h0005);
    chk("swp.dp", dp, 16'h1235);

    // Wrap: both byte enables load the same byte, then jump to FFFF and increment
    step("wboth", 0, 0, 0, 0, 8'hFF);
    chk("wboth.dp", dp, 16'hFFFF);
    step("swpff", 0, 1, 1, 1, 8'h00);
    step("wrap", 1, 0, 1, 1, 8'h00);
    chk("wrap.ip", ip, 16'h0000);
    step("wboth2", 0, 0, 0, 0, 8'hFF);
    step("swpff2", 0, 1, 1, 1, 8'h00);
    step("wpl34b", 0, 0, 0, 1, 8'h34);
    step("wph12b", 0, 0, 1, 0, 8'h12);
    step("swpincw", 1, 1, 0, 1, 8'hAA);
    chk("swpincw.ip", ip, 16'h1235);
    chk("swpincw.dp", dp, 16'hFFAA);

    // ALU B drive and conflict
    step("wpl34c", 0, 0, 0, 1, 8'h34);
    step("wph12c", 0, 0, 1, 0, 8'h12);
    oe_pl_alu = 1'b0; oe_ph_alu = 1'b0; #1;
    chk("cfl.alub", {8'h00, alu_b}, 16'h0034);
    chk("cfl.flag", {15'd0, oe_conflict}, 16'h0001);
    oe_ph_alu = 1'b1; #1;
    chk("pl.alub", {8'h00, alu_b}, 16'h0034);
    oe_pl_alu = 1'b1; #1;
    chk("off.alub", {8'h00, alu_b}, 16'h0000);
    chk("off.drv", {15'd0, alu_b_drive}, 16'h0000);

    // Mid-cycle async reset
    step("w21", 0, 0, 0, 1, 8'h21);
    step("w43", 0, 0, 1, 0, 8'h43);
    step("swp4321", 0, 1, 1, 1, 8'h00);
    chk("pre.ip", ip, 16'h4321);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("arst.ip", ip, 16'h0000);
    chk("arst.dp", dp, 16'h0000);
    addr_dp = 1'b1; #1;
    chk("arst.addr", addr, 16'h0000);
    addr_dp = 1'b0;
    rst = 1'b1;
    m_ip = 16'h0000; m_dp = 16'h0000;
    step("postrst", 1, 0, 1, 1, 8'h00);
    chk("postrst.ip", ip, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
